// File: rtl/neuron_mac_lanes.sv
// Multi-lane fixed-point neuron. It accumulates the weighted inputs with saturation,
// adds a runtime bias, rescales the sum and applies relu or linear activation.
module neuron_mac_lanes #(
  parameter int    layerNo   = 0,
  parameter int    neuronNo  = 0,
  parameter int    numWeight = 784,
  parameter int    lanes     = 4,
  parameter int    dataWidth = 16,
  parameter int    fracBits  = 8,
  parameter int    accGuard  = 8,
  parameter string actType   = "relu"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [lanes*dataWidth-1:0] inData,
  input  logic                       weightValid,
  input  logic [31:0]                weightValue,
  input  logic                       biasValid,
  input  logic [31:0]                biasValue,
  input  logic [31:0]                configLayerNum,
  input  logic [31:0]                configNeuronNum,
  output logic [dataWidth-1:0]       out,
  output logic                       outValid,
  output logic                       loadErr
);
  localparam int AccW     = 2*dataWidth + accGuard;
  localparam int ProdW    = 2*dataWidth;
  localparam int SumW     = ProdW + $clog2(lanes) + 1;
  localparam int NumBeats = numWeight / lanes;
  localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int PtrW     = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int Max1     = (AccW > SumW) ? AccW : SumW;
  localparam int Max2     = (Max1 > dataWidth + fracBits) ? Max1 : dataWidth + fracBits;
  localparam int ExtW     = Max2 + 1;
  localparam bit IsRelu   = (actType == "relu");

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] BIAS  = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  localparam logic signed [ExtW-1:0] AccMaxE = {{(ExtW-AccW+1){1'b0}}, {(AccW-1){1'b1}}};
  localparam logic signed [ExtW-1:0] AccMinE = {{(ExtW-AccW+1){1'b1}}, {(AccW-1){1'b0}}};
  localparam logic signed [AccW-1:0] OutMaxA = {{(AccW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [AccW-1:0] OutMinA = {{(AccW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

  logic [1:0]                  state_q, state_d;
  logic [BeatW-1:0]            beat_cnt_q, beat_cnt_d;
  logic                        drain_q, drain_d;
  logic [PtrW-1:0]             ptr_q;
  logic signed [dataWidth-1:0] bias_q;
  logic                        load_err_q;
  logic signed [AccW-1:0]      acc_q, acc_d;
  logic                        v0_q, v1_q;
  logic [dataWidth-1:0]        out_q;
  logic                        out_valid_q;

  logic signed [dataWidth-1:0] weight_mem [numWeight];
  logic signed [dataWidth-1:0] x_q [lanes];
  logic signed [dataWidth-1:0] w_q [lanes];
  logic signed [ProdW-1:0]     prod_q [lanes];

  logic                        beat_fire, cfg_match, cfg_idle, wr_weight, wr_bias, wr_drop;
  logic signed [SumW-1:0]      lane_sum;
  logic signed [ExtW-1:0]      acc_ext, sum_ext, bias_sx, bias_ext;
  logic signed [AccW-1:0]      acc_shr;
  logic [dataWidth-1:0]        result;

  assign inReady   = (state_q == RUN) && !rst;
  assign beat_fire = inValid && inReady;

  // Config writes land only between inferences so a running sum never sees mixed weights.
  assign cfg_match = (configLayerNum == 32'(layerNo)) && (configNeuronNum == 32'(neuronNo));
  assign cfg_idle  = (state_q == RUN) && (beat_cnt_q == '0);
  assign wr_weight = weightValid && cfg_match && cfg_idle && !rst;
  assign wr_bias   = biasValid && cfg_match && cfg_idle && !rst;
  assign wr_drop   = (weightValid || biasValid) && cfg_match && !cfg_idle;

  generate
    if (dataWidth < 32) begin : g_unused
      logic unused_cfg_hi;
      assign unused_cfg_hi = ^{weightValue[31:dataWidth], biasValue[31:dataWidth]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_weight) weight_mem[ptr_q] <= weightValue[dataWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      bias_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      if (wr_weight) ptr_q <= (ptr_q == PtrW'(numWeight-1)) ? '0 : ptr_q + 1'b1;
      if (wr_bias) bias_q <= biasValue[dataWidth-1:0];
      if (wr_drop) load_err_q <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
      logic [PtrW-1:0] rd_idx;
      assign rd_idx = PtrW'(int'(beat_cnt_q) * lanes + gi);
      always_ff @(posedge clk) begin
        if (beat_fire) begin
          x_q[gi] <= inData[gi*dataWidth +: dataWidth];
          w_q[gi] <= weight_mem[rd_idx];
        end
        prod_q[gi] <= x_q[gi] * w_q[gi];
      end
    end
  endgenerate

  // Sum is wide enough to be exact; saturation happens only at the accumulator.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < lanes; i++) begin
      lane_sum = lane_sum + {{(SumW-ProdW){prod_q[i][ProdW-1]}}, prod_q[i]};
    end
  end

  function automatic logic [AccW-1:0] sat_add(input logic signed [ExtW-1:0] a,
                                              input logic signed [ExtW-1:0] b);
    logic signed [ExtW-1:0] s;
    s = a + b;
    if (s > AccMaxE)      sat_add = AccMaxE[AccW-1:0];
    else if (s < AccMinE) sat_add = AccMinE[AccW-1:0];
    else                  sat_add = s[AccW-1:0];
  endfunction

  assign acc_ext  = {{(ExtW-AccW){acc_q[AccW-1]}}, acc_q};
  assign sum_ext  = {{(ExtW-SumW){lane_sum[SumW-1]}}, lane_sum};
  assign bias_sx  = {{(ExtW-dataWidth){bias_q[dataWidth-1]}}, bias_q};
  assign bias_ext = bias_sx <<< fracBits;

  always_comb begin
    acc_d = acc_q;
    if (state_q == EMIT)       acc_d = '0;
    else if (v1_q)             acc_d = sat_add(acc_ext, sum_ext);
    else if (state_q == BIAS)  acc_d = sat_add(acc_ext, bias_ext);
  end

  assign acc_shr = acc_q >>> fracBits;

  always_comb begin
    if (acc_shr > OutMaxA)      result = OutMaxA[dataWidth-1:0];
    else if (acc_shr < OutMinA) result = OutMinA[dataWidth-1:0];
    else                        result = acc_shr[dataWidth-1:0];
    if (IsRelu && result[dataWidth-1]) result = '0;
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    drain_d    = drain_q;
    case (state_q)
      RUN: begin
        if (beat_fire) begin
          if (beat_cnt_q == BeatW'(NumBeats-1)) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = BIAS;
      end
      BIAS: state_d = EMIT;
      default: begin
        state_d    = RUN;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      beat_cnt_q  <= '0;
      drain_q     <= 1'b0;
      acc_q       <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_q     <= drain_d;
      acc_q       <= acc_d;
      v0_q        <= beat_fire;
      v1_q        <= v0_q;
      out_valid_q <= (state_q == EMIT);
      if (state_q == EMIT) out_q <= result;
    end
  end

  assign out      = out_q;
  assign outValid = out_valid_q;
  assign loadErr  = load_err_q;

endmodule
